// File: rtl/axi_rr_arbiter_pkg.sv
// Shared types for the N-master AXI4 round-robin arbiter.
package axi_rr_arbiter_pkg;

  typedef enum logic {R_IDLE, R_BUSY} rd_state_t;
  typedef enum logic {W_IDLE, W_BUSY} wr_state_t;

endpackage

// File: rtl/axi_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [MASTER_NUM-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  localparam logic [IDX_W:0] NUM = (IDX_W+1)'(MASTER_NUM);

  logic [2*MASTER_NUM-1:0] dbl;
  logic [IDX_W:0]          pos;
  logic [IDX_W:0]          sum;
  logic [IDX_W-1:0]        off;
  logic                    found;

  // Two copies of req side by side let a search from ptr wrap without a modulo.
  assign dbl = {req, req};

  always_comb begin
    off   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (!found && dbl[pos]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM) sum = sum - NUM;
    idx    = sum[IDX_W-1:0];
    any    = found;
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter; independent round-robin read and write grants held per transaction.
module axi_rr_arbiter
  import axi_rr_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_NUM-1:0]              s_awvalid_i,
  output logic [MASTER_NUM-1:0]              s_awready_o,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic [MASTER_NUM*ID_WIDTH-1:0]     s_awid_i,
  input  logic [MASTER_NUM*8-1:0]            s_awlen_i,
  input  logic [MASTER_NUM*3-1:0]            s_awsize_i,
  input  logic [MASTER_NUM*2-1:0]            s_awburst_i,
  input  logic [MASTER_NUM-1:0]              s_wvalid_i,
  output logic [MASTER_NUM-1:0]              s_wready_o,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [MASTER_NUM*DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic [MASTER_NUM-1:0]              s_wlast_i,
  output logic [MASTER_NUM-1:0]              s_bvalid_o,
  input  logic [MASTER_NUM-1:0]              s_bready_i,
  output logic [MASTER_NUM*2-1:0]            s_bresp_o,
  output logic [MASTER_NUM*ID_WIDTH-1:0]     s_bid_o,
  input  logic [MASTER_NUM-1:0]              s_arvalid_i,
  output logic [MASTER_NUM-1:0]              s_arready_o,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic [MASTER_NUM*ID_WIDTH-1:0]     s_arid_i,
  input  logic [MASTER_NUM*8-1:0]            s_arlen_i,
  input  logic [MASTER_NUM*3-1:0]            s_arsize_i,
  input  logic [MASTER_NUM*2-1:0]            s_arburst_i,
  output logic [MASTER_NUM-1:0]              s_rvalid_o,
  input  logic [MASTER_NUM-1:0]              s_rready_i,
  output logic [MASTER_NUM*DATA_WIDTH-1:0]   s_rdata_o,
  output logic [MASTER_NUM*2-1:0]            s_rresp_o,
  output logic [MASTER_NUM*ID_WIDTH-1:0]     s_rid_o,
  output logic [MASTER_NUM-1:0]              s_rlast_o,
  output logic                               m_awvalid_o,
  input  logic                               m_awready_i,
  output logic [ADDR_WIDTH-1:0]              m_awaddr_o,
  output logic [ID_WIDTH-1:0]                m_awid_o,
  output logic [7:0]                         m_awlen_o,
  output logic [2:0]                         m_awsize_o,
  output logic [1:0]                         m_awburst_o,
  output logic                               m_wvalid_o,
  input  logic                               m_wready_i,
  output logic [DATA_WIDTH-1:0]              m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            m_wstrb_o,
  output logic                               m_wlast_o,
  input  logic                               m_bvalid_i,
  output logic                               m_bready_o,
  input  logic [1:0]                         m_bresp_i,
  input  logic [ID_WIDTH-1:0]                m_bid_i,
  output logic                               m_arvalid_o,
  input  logic                               m_arready_i,
  output logic [ADDR_WIDTH-1:0]              m_araddr_o,
  output logic [ID_WIDTH-1:0]                m_arid_o,
  output logic [7:0]                         m_arlen_o,
  output logic [2:0]                         m_arsize_o,
  output logic [1:0]                         m_arburst_o,
  input  logic                               m_rvalid_i,
  output logic                               m_rready_o,
  input  logic [DATA_WIDTH-1:0]              m_rdata_i,
  input  logic [1:0]                         m_rresp_i,
  input  logic [ID_WIDTH-1:0]                m_rid_i,
  input  logic                               m_rlast_i
);

  localparam int unsigned     IDX_W    = $clog2(MASTER_NUM);
  localparam int unsigned     STRB_W   = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASTER_NUM - 1);

  rd_state_t rd_state, rd_state_nxt;
  wr_state_t wr_state, wr_state_nxt;

  logic [IDX_W-1:0]      rd_owner, rd_ptr, rd_cand_idx;
  logic [IDX_W-1:0]      wr_owner, wr_ptr, wr_cand_idx;
  logic [MASTER_NUM-1:0] rd_cand_oh, rd_owner_oh, rd_gnt;
  logic [MASTER_NUM-1:0] wr_cand_oh, wr_owner_oh, wr_gnt;
  logic                  rd_cand_any, wr_cand_any;
  logic                  rd_done, wr_done;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] owner);
    return (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
  endfunction

  rr_picker #(.MASTER_NUM(MASTER_NUM), .IDX_W(IDX_W)) u_rd_pick (
    .req(s_arvalid_i), .ptr(rd_ptr), .onehot(rd_cand_oh), .idx(rd_cand_idx), .any(rd_cand_any)
  );

  rr_picker #(.MASTER_NUM(MASTER_NUM), .IDX_W(IDX_W)) u_wr_pick (
    .req(s_awvalid_i), .ptr(wr_ptr), .onehot(wr_cand_oh), .idx(wr_cand_idx), .any(wr_cand_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_owner <= '0;
      rd_ptr   <= '0;
      wr_state <= W_IDLE;
      wr_owner <= '0;
      wr_ptr   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      wr_state <= wr_state_nxt;
      if (rd_state == R_IDLE && rd_cand_any) rd_owner <= rd_cand_idx;
      if (wr_state == W_IDLE && wr_cand_any) wr_owner <= wr_cand_idx;
      if (rd_done) rd_ptr <= ptr_after(rd_owner);
      if (wr_done) wr_ptr <= ptr_after(wr_owner);
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    wr_state_nxt = wr_state;
    unique case (rd_state)
      R_IDLE: if (rd_cand_any) rd_state_nxt = R_BUSY;
      R_BUSY: if (rd_done)     rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
    unique case (wr_state)
      W_IDLE: if (wr_cand_any) wr_state_nxt = W_BUSY;
      W_BUSY: if (wr_done)     wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // In IDLE the live candidate is granted so the request passes through with zero latency.
  always_comb begin
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      rd_owner_oh[i] = (IDX_W'(i) == rd_owner);
      wr_owner_oh[i] = (IDX_W'(i) == wr_owner);
    end
    rd_gnt = '0;
    wr_gnt = '0;
    if (!reset) begin
      rd_gnt = (rd_state == R_IDLE) ? rd_cand_oh : rd_owner_oh;
      wr_gnt = (wr_state == W_IDLE) ? wr_cand_oh : wr_owner_oh;
    end
  end

  assign rd_done = (rd_state == R_BUSY) && m_rvalid_i && m_rready_o && m_rlast_i;
  assign wr_done = (wr_state == W_BUSY) && m_bvalid_i && m_bready_o;

  always_comb begin
    m_arvalid_o = |(s_arvalid_i & rd_gnt);
    m_rready_o  = |(s_rready_i & rd_gnt);
    s_arready_o = rd_gnt & {MASTER_NUM{m_arready_i}};
    s_rvalid_o  = rd_gnt & {MASTER_NUM{m_rvalid_i}};
    s_rlast_o   = rd_gnt & {MASTER_NUM{m_rlast_i}};
    m_araddr_o  = '0;
    m_arid_o    = '0;
    m_arlen_o   = '0;
    m_arsize_o  = '0;
    m_arburst_o = '0;
    s_rdata_o   = '0;
    s_rresp_o   = '0;
    s_rid_o     = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (rd_gnt[i]) begin
        m_araddr_o                        = s_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_arid_o                          = s_arid_i[i*ID_WIDTH +: ID_WIDTH];
        m_arlen_o                         = s_arlen_i[i*8 +: 8];
        m_arsize_o                        = s_arsize_i[i*3 +: 3];
        m_arburst_o                       = s_arburst_i[i*2 +: 2];
        s_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata_i;
        s_rresp_o[i*2 +: 2]               = m_rresp_i;
        s_rid_o[i*ID_WIDTH +: ID_WIDTH]   = m_rid_i;
      end
    end
  end

  always_comb begin
    m_awvalid_o = |(s_awvalid_i & wr_gnt);
    m_wvalid_o  = |(s_wvalid_i & wr_gnt);
    m_bready_o  = |(s_bready_i & wr_gnt);
    s_awready_o = wr_gnt & {MASTER_NUM{m_awready_i}};
    s_wready_o  = wr_gnt & {MASTER_NUM{m_wready_i}};
    s_bvalid_o  = wr_gnt & {MASTER_NUM{m_bvalid_i}};
    m_awaddr_o  = '0;
    m_awid_o    = '0;
    m_awlen_o   = '0;
    m_awsize_o  = '0;
    m_awburst_o = '0;
    m_wdata_o   = '0;
    m_wstrb_o   = '0;
    m_wlast_o   = 1'b0;
    s_bresp_o   = '0;
    s_bid_o     = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (wr_gnt[i]) begin
        m_awaddr_o                      = s_awaddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_awid_o                        = s_awid_i[i*ID_WIDTH +: ID_WIDTH];
        m_awlen_o                       = s_awlen_i[i*8 +: 8];
        m_awsize_o                      = s_awsize_i[i*3 +: 3];
        m_awburst_o                     = s_awburst_i[i*2 +: 2];
        m_wdata_o                       = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb_o                       = s_wstrb_i[i*STRB_W +: STRB_W];
        m_wlast_o                       = s_wlast_i[i];
        s_bresp_o[i*2 +: 2]             = m_bresp_i;
        s_bid_o[i*ID_WIDTH +: ID_WIDTH] = m_bid_i;
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Randomised and directed bench for axi_rr_arbiter against a per-cycle round-robin reference model.
module tb_axi_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]    s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o, s_wlast_i, s_bvalid_o, s_bready_i;
  logic [N-1:0]    s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i, s_rlast_o;
  logic [N*AW-1:0] s_awaddr_i, s_araddr_i;
  logic [N*IW-1:0] s_awid_i, s_arid_i, s_bid_o, s_rid_o;
  logic [N*8-1:0]  s_awlen_i, s_arlen_i;
  logic [N*3-1:0]  s_awsize_i, s_arsize_i;
  logic [N*2-1:0]  s_awburst_i, s_arburst_i, s_bresp_o, s_rresp_o;
  logic [N*DW-1:0] s_wdata_i, s_rdata_o;
  logic [N*SW-1:0] s_wstrb_i;

  logic          m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i, m_wlast_o, m_bvalid_i, m_bready_o;
  logic          m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
  logic [AW-1:0] m_awaddr_o, m_araddr_o;
  logic [IW-1:0] m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [7:0]    m_awlen_o, m_arlen_o;
  logic [2:0]    m_awsize_o, m_arsize_o;
  logic [1:0]    m_awburst_o, m_arburst_o, m_bresp_i, m_rresp_i;
  logic [DW-1:0] m_wdata_o, m_rdata_i;
  logic [SW-1:0] m_wstrb_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_rr_arbiter #(.MASTER_NUM(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i), .s_awid_i(s_awid_i),
    .s_awlen_i(s_awlen_i), .s_awsize_i(s_awsize_i), .s_awburst_i(s_awburst_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_wlast_i(s_wlast_i), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
    .s_bid_o(s_bid_o), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i), .s_arsize_i(s_arsize_i), .s_arburst_i(s_arburst_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o), .m_awid_o(m_awid_o),
    .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_wlast_o(m_wlast_o), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .m_bid_i(m_bid_i), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one busy flag, owner and pointer per channel group.
  int rd_busy = 0, rd_own = 0, rd_ptr = 0, wr_busy = 0, wr_own = 0, wr_ptr = 0;
  int n_rd_busy = 0, n_rd_own = 0, n_rd_ptr = 0, n_wr_busy = 0, n_wr_own = 0, n_wr_ptr = 0;

  always @(posedge clk) begin
    rd_busy <= n_rd_busy; rd_own <= n_rd_own; rd_ptr <= n_rd_ptr;
    wr_busy <= n_wr_busy; wr_own <= n_wr_own; wr_ptr <= n_wr_ptr;
  end

  bit rh, wh, e_rrdy, e_brdy;
  int ri, wi;
  logic [N-1:0]    roh, woh;
  logic [N*DW-1:0] e_rdata;
  logic [N*2-1:0]  e_rresp, e_bresp;
  logic [N*IW-1:0] e_rid, e_bid;

  always @(negedge clk) begin
    rh = 0; ri = 0; wh = 0; wi = 0;
    if (!reset) begin
      if (rd_busy != 0) begin rh = 1; ri = rd_own; end
      else for (int k = 0; k < N; k++)
        if (!rh && s_arvalid_i[(rd_ptr + k) % N]) begin rh = 1; ri = (rd_ptr + k) % N; end
      if (wr_busy != 0) begin wh = 1; wi = wr_own; end
      else for (int k = 0; k < N; k++)
        if (!wh && s_awvalid_i[(wr_ptr + k) % N]) begin wh = 1; wi = (wr_ptr + k) % N; end
    end
    roh = '0; woh = '0; e_rdata = '0; e_rresp = '0; e_rid = '0; e_bresp = '0; e_bid = '0;
    if (rh) begin
      roh[ri] = 1'b1;
      e_rdata[ri*DW +: DW] = m_rdata_i;
      e_rresp[ri*2 +: 2]   = m_rresp_i;
      e_rid[ri*IW +: IW]   = m_rid_i;
    end
    if (wh) begin
      woh[wi] = 1'b1;
      e_bresp[wi*2 +: 2] = m_bresp_i;
      e_bid[wi*IW +: IW] = m_bid_i;
    end
    e_rrdy = rh && s_rready_i[ri];
    e_brdy = wh && s_bready_i[wi];

    check_eq("rd_ctrl", {m_arvalid_o, m_rready_o, s_arready_o, s_rvalid_o, s_rlast_o},
             {rh && s_arvalid_i[ri], e_rrdy, roh & {N{m_arready_i}}, roh & {N{m_rvalid_i}}, roh & {N{m_rlast_i}}});
    check_eq("rd_resp", {s_rdata_o, s_rresp_o, s_rid_o}, {e_rdata, e_rresp, e_rid});
    if (rh)
      check_eq("ar_fields", {m_araddr_o, m_arid_o, m_arlen_o, m_arsize_o, m_arburst_o},
               {s_araddr_i[ri*AW +: AW], s_arid_i[ri*IW +: IW], s_arlen_i[ri*8 +: 8],
                s_arsize_i[ri*3 +: 3], s_arburst_i[ri*2 +: 2]});
    check_eq("wr_ctrl", {m_awvalid_o, m_wvalid_o, m_bready_o, s_awready_o, s_wready_o, s_bvalid_o},
             {wh && s_awvalid_i[wi], wh && s_wvalid_i[wi], e_brdy,
              woh & {N{m_awready_i}}, woh & {N{m_wready_i}}, woh & {N{m_bvalid_i}}});
    check_eq("wr_resp", {s_bresp_o, s_bid_o}, {e_bresp, e_bid});
    if (wh) begin
      check_eq("aw_fields", {m_awaddr_o, m_awid_o, m_awlen_o, m_awsize_o, m_awburst_o},
               {s_awaddr_i[wi*AW +: AW], s_awid_i[wi*IW +: IW], s_awlen_i[wi*8 +: 8],
                s_awsize_i[wi*3 +: 3], s_awburst_i[wi*2 +: 2]});
      check_eq("w_fields", {m_wdata_o, m_wstrb_o, m_wlast_o},
               {s_wdata_i[wi*DW +: DW], s_wstrb_i[wi*SW +: SW], s_wlast_i[wi]});
    end

    n_rd_busy = rd_busy; n_rd_own = rd_own; n_rd_ptr = rd_ptr;
    n_wr_busy = wr_busy; n_wr_own = wr_own; n_wr_ptr = wr_ptr;
    if (reset) begin
      n_rd_busy = 0; n_rd_own = 0; n_rd_ptr = 0;
      n_wr_busy = 0; n_wr_own = 0; n_wr_ptr = 0;
    end else begin
      if (rd_busy == 0 && rh) begin n_rd_busy = 1; n_rd_own = ri; end
      else if (rd_busy != 0 && m_rvalid_i && e_rrdy && m_rlast_i) begin n_rd_busy = 0; n_rd_ptr = (rd_own + 1) % N; end
      if (wr_busy == 0 && wh) begin n_wr_busy = 1; n_wr_own = wi; end
      else if (wr_busy != 0 && m_bvalid_i && e_brdy) begin n_wr_busy = 0; n_wr_ptr = (wr_own + 1) % N; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awvalid_i = '0; s_awaddr_i = '0; s_awid_i = '0; s_awlen_i = '0; s_awsize_i = '0; s_awburst_i = '0;
    s_wvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_wlast_i = '0; s_bready_i = '0;
    s_arvalid_i = '0; s_araddr_i = '0; s_arid_i = '0; s_arlen_i = '0; s_arsize_i = '0; s_arburst_i = '0;
    s_rready_i = '0;
    m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = '0; m_bid_i = '0;
    m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rid_i = '0; m_rlast_i = 1'b0;
  endtask

  task automatic random_inputs();
    s_awvalid_i = N'($urandom); s_awaddr_i = {$urandom, $urandom, $urandom}; s_awid_i = (N*IW)'($urandom);
    s_awlen_i = (N*8)'($urandom); s_awsize_i = (N*3)'($urandom); s_awburst_i = (N*2)'($urandom);
    s_wvalid_i = N'($urandom); s_wdata_i = {$urandom, $urandom, $urandom}; s_wstrb_i = (N*SW)'($urandom);
    s_wlast_i = N'($urandom); s_bready_i = N'($urandom);
    s_arvalid_i = N'($urandom); s_araddr_i = {$urandom, $urandom, $urandom}; s_arid_i = (N*IW)'($urandom);
    s_arlen_i = (N*8)'($urandom); s_arsize_i = (N*3)'($urandom); s_arburst_i = (N*2)'($urandom);
    s_rready_i = N'($urandom);
    m_awready_i = 1'($urandom); m_wready_i = 1'($urandom); m_bvalid_i = 1'($urandom);
    m_bresp_i = 2'($urandom); m_bid_i = IW'($urandom);
    m_arready_i = 1'($urandom); m_rvalid_i = 1'($urandom); m_rdata_i = $urandom;
    m_rresp_i = 2'($urandom); m_rid_i = IW'($urandom); m_rlast_i = ($urandom_range(0, 2) == 0);
    reset = ($urandom_range(0, 249) == 0);
  endtask

  logic [N-1:0] order_q[$];
  logic [N-1:0] exp_order[4];
  logic [N-1:0] prev_gnt;

  initial begin
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    clear_inputs();
    repeat (2) step();
    reset = 1'b0;

    // Three masters each hold single-beat reads; grants rotate 0,1,2,0.
    s_arvalid_i = 3'b111; s_araddr_i = {32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    m_arready_i = 1'b1; m_rvalid_i = 1'b1; m_rlast_i = 1'b1; s_rready_i = 3'b111; m_rdata_i = 32'hA5A5_0001;
    prev_gnt = '0;
    repeat (8) begin
      @(negedge clk);
      if (s_arready_o != '0 && s_arready_o != prev_gnt) order_q.push_back(s_arready_o);
      prev_gnt = s_arready_o;
    end
    check_eq("rd_order_len", 128'(order_q.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      if (i < order_q.size()) check_eq($sformatf("rd_order%0d", i), order_q[i], exp_order[i]);

    // Master 2 presents W two cycles ahead of AW; grant follows AW and holds through B.
    step(); reset = 1'b1; clear_inputs(); step(); reset = 1'b0;
    s_wvalid_i = 3'b100; s_wdata_i = {32'hDEAD_BEEF, 64'h0}; s_wstrb_i = 12'hF00; s_wlast_i = 3'b100;
    m_wready_i = 1'b1; s_bready_i = 3'b100; m_awready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("w_early", s_wready_o, '0);
      step();
    end
    s_awvalid_i = 3'b100; s_awaddr_i = {32'h8000_0000, 64'h0};
    @(negedge clk);
    check_eq("aw_grant", {s_awready_o, s_wready_o}, {3'b100, 3'b100});
    step();
    s_awvalid_i = '0; s_wvalid_i = '0; m_bvalid_i = 1'b1; m_bresp_i = 2'b00;
    @(negedge clk);
    check_eq("b_route", s_bvalid_o, 3'b100);
    step();
    m_bvalid_i = 1'b0; s_bready_i = '0; s_awvalid_i = 3'b011;
    @(negedge clk);
    check_eq("wr_ptr_wrap", s_awready_o, 3'b001);

    // Reset lands on beat 2 of a 4-beat read; afterwards master 1 is granted at once.
    step(); reset = 1'b1; clear_inputs(); step(); reset = 1'b0;
    s_arvalid_i = 3'b010; s_arlen_i = 24'h00_03_00; m_arready_i = 1'b1; s_rready_i = 3'b011;
    step();
    s_arvalid_i = '0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0B01;
    step();
    m_rdata_i = 32'h0000_0B02; reset = 1'b1;
    s_arvalid_i = 3'b010; s_awvalid_i = 3'b010; s_wvalid_i = 3'b010; m_bvalid_i = 1'b1; s_bready_i = 3'b010;
    m_awready_i = 1'b1; m_wready_i = 1'b1;
    @(negedge clk);
    check_eq("rst_valids", {m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o,
                            s_rvalid_o, s_arready_o, s_bvalid_o, s_awready_o, s_wready_o}, '0);
    step();
    reset = 1'b0; clear_inputs(); s_arvalid_i = 3'b010; m_arready_i = 1'b1;
    @(negedge clk);
    check_eq("post_rst_gnt", s_arready_o, 3'b010);

    // Free-running random traffic, including withdrawals and occasional resets.
    repeat (3000) begin
      step();
      random_inputs();
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
